// File: rtl/stream_sink_checker.sv
// rtl/stream_sink_checker.sv - self-checking sink for a vld/rdy/fst float_24_8 stream
//
// Purpose:
//   Accepts beats under a rotating backpressure pattern, compares each beat
//   with an expected-value RAM indexed by frame position, and counts data
//   mismatches and first-of-frame framing errors. Signals completion once
//   num_frames frames of frame_len words have been accepted.
//
// Build option:
//   STREAM_CHECK_TOL_EN  when defined, a beat matches if |in_data - exp| <= TOL
//                        (unsigned raw words); otherwise an exact match is required.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start                       one-cycle pulse arming a run (ignored while busy)
//   frame_len, num_frames,
//   rdy_pattern                 run configuration, sampled at start
//   exp_wr_en/addr/data         expected-RAM write port, usable in any state
//   in_data, in_vld, in_fst     incoming stream
//   in_rdy                      stream ready (rotating pattern bit while running)
//   busy, done                  run in progress / run complete
//   err_cnt                     saturating data-mismatch count
//   fst_err                     sticky framing error
//   first_err_idx               global beat index of first mismatch, all-ones if none
//   word_cnt                    beats accepted this run

module stream_sink_checker #(
    parameter int DW  = 32,
    parameter int AW  = 7,
    parameter int TOL = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   frame_len,
    input  logic [15:0]   num_frames,
    input  logic [7:0]    rdy_pattern,
    input  logic          exp_wr_en,
    input  logic [AW-1:0] exp_wr_addr,
    input  logic [DW-1:0] exp_wr_data,
    input  logic [DW-1:0] in_data,
    input  logic          in_vld,
    input  logic          in_fst,
    output logic          in_rdy,
    output logic          busy,
    output logic          done,
    output logic [15:0]   err_cnt,
    output logic          fst_err,
    output logic [31:0]   first_err_idx,
    output logic [31:0]   word_cnt
);

    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [7:0]    rot;
    logic [AW:0]   fl;
    logic [15:0]   nf;
    logic [AW-1:0] idx;
    logic [15:0]   frm;
    logic [31:0]   wc;
    logic [15:0]   err_r;
    logic          fst_r;
    logic [31:0]   first_r;

    // Compare pipeline stage, loaded on accept and folded into the
    // counters on the following cycle.
    logic          p_vld;
    logic [DW-1:0] p_data;
    logic [DW-1:0] p_exp;
    logic          p_idx0;
    logic          p_fst;
    logic [31:0]   p_wc;

    logic [DW-1:0] exp_ram [DEPTH];

    logic [AW:0]   depth_l;
    logic [AW:0]   fl_clamped;
    logic [7:0]    pat_fixed;
    logic          accept;
    logic          idx_last;
    logic          frm_last;
    logic          mis;
    logic          fst_bad;
    logic          err_inc;
    logic          first_set;

    assign depth_l = {1'b1, {AW{1'b0}}};

    always_comb begin
        fl_clamped = frame_len;
        if (frame_len == '0) begin
            fl_clamped = {{AW{1'b0}}, 1'b1};
        end else if (frame_len > depth_l) begin
            fl_clamped = depth_l;
        end
    end

    assign pat_fixed = (rdy_pattern == 8'h00) ? 8'hFF : rdy_pattern;

    // A zero-frame run must finish without taking a beat, so ready stays low.
    assign in_rdy   = (state == S_RUN) && rot[0] && (nf != 16'd0);
    assign accept   = in_vld && in_rdy;
    assign idx_last = ({1'b0, idx} == (fl - {{AW{1'b0}}, 1'b1}));
    assign frm_last = (frm == (nf - 16'd1));

`ifdef STREAM_CHECK_TOL_EN
    logic [DW-1:0] diff;
    always_comb begin
        diff = (p_data >= p_exp) ? (p_data - p_exp) : (p_exp - p_data);
    end
    assign mis = (diff > DW'(TOL));
`else
    logic tol_unused;
    assign tol_unused = ^TOL;
    assign mis = (p_data != p_exp);
`endif

    assign fst_bad   = p_vld && (p_fst != p_idx0);
    assign err_inc   = p_vld && mis && (err_r != 16'hFFFF);
    assign first_set = p_vld && mis && (first_r == 32'hFFFF_FFFF);

    // Outputs include the pending pipeline result so the last beat's verdict
    // is already visible in the cycle done rises.
    assign err_cnt       = err_inc ? (err_r + 16'd1) : err_r;
    assign first_err_idx = first_set ? p_wc : first_r;
    assign fst_err       = fst_r || fst_bad;
    assign word_cnt      = wc;
    assign busy          = (state == S_RUN);
    assign done          = (state == S_DONE);

    // Expected RAM: not reset; a read in the same cycle sees the old word.
    always_ff @(posedge clk) begin
        if (exp_wr_en) begin
            exp_ram[exp_wr_addr] <= exp_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            p_data <= in_data;
            p_exp  <= exp_ram[idx];
            p_idx0 <= (idx == '0);
            p_fst  <= in_fst;
            p_wc   <= wc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            rot     <= 8'h00;
            fl      <= '0;
            nf      <= 16'd0;
            idx     <= '0;
            frm     <= 16'd0;
            wc      <= 32'd0;
            err_r   <= 16'd0;
            fst_r   <= 1'b0;
            first_r <= 32'hFFFF_FFFF;
            p_vld   <= 1'b0;
        end else begin
            p_vld <= accept;
            if (err_inc)   err_r   <= err_r + 16'd1;
            if (first_set) first_r <= p_wc;
            if (fst_bad)   fst_r   <= 1'b1;

            case (state)
                S_RUN: begin
                    rot <= {rot[0], rot[7:1]};
                    if (nf == 16'd0) begin
                        state <= S_DONE;
                    end
                    if (accept) begin
                        wc <= wc + 32'd1;
                        if (idx_last) begin
                            idx <= '0;
                            frm <= frm + 16'd1;
                            if (frm_last) begin
                                state <= S_DONE;
                            end
                        end else begin
                            idx <= idx + {{(AW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state   <= S_RUN;
                        rot     <= pat_fixed;
                        fl      <= fl_clamped;
                        nf      <= num_frames;
                        idx     <= '0;
                        frm     <= 16'd0;
                        wc      <= 32'd0;
                        err_r   <= 16'd0;
                        fst_r   <= 1'b0;
                        first_r <= 32'hFFFF_FFFF;
                        p_vld   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_sink_checker.sv
// tb/tb_stream_sink_checker.sv - randomized self-checking bench for stream_sink_checker

module tb_stream_sink_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  frame_len;
    logic [15:0] num_frames;
    logic [7:0]  rdy_pattern;
    logic        exp_wr_en;
    logic [6:0]  exp_wr_addr;
    logic [31:0] exp_wr_data;
    logic [31:0] in_data;
    logic        in_vld;
    logic        in_fst;
    logic        in_rdy;
    logic        busy;
    logic        done;
    logic [15:0] err_cnt;
    logic        fst_err;
    logic [31:0] first_err_idx;
    logic [31:0] word_cnt;

    always #5 clk = ~clk;

    stream_sink_checker #(.DW(32), .AW(7), .TOL(1)) dut (
        .clk(clk), .reset(reset), .start(start),
        .frame_len(frame_len), .num_frames(num_frames), .rdy_pattern(rdy_pattern),
        .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
        .in_data(in_data), .in_vld(in_vld), .in_fst(in_fst), .in_rdy(in_rdy),
        .busy(busy), .done(done), .err_cnt(err_cnt), .fst_err(fst_err),
        .first_err_idx(first_err_idx), .word_cnt(word_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference copy of the expected RAM.
    logic [31:0] mram [128];

    // Per-run fault injection knobs (-1 = none).
    int corrupt_beat;
    int corrupt_delta;
    int fst_beat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit beat_bad(input logic [31:0] d, input logic [31:0] e);
        logic [31:0] diff;
        diff = (d >= e) ? d - e : e - d;
`ifdef STREAM_CHECK_TOL_EN
        return diff > 32'd1;
`else
        return diff != 32'd0;
`endif
    endfunction

    task automatic load_ram(input bit rnd);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            mram[i]     = rnd ? $urandom : 32'(i);
            exp_wr_en   = 1'b1;
            exp_wr_addr = 7'(i);
            exp_wr_data = mram[i];
        end
        @(negedge clk);
        exp_wr_en = 1'b0;
    endtask

    task automatic run(input string name, input int fl_in, input int nf, input logic [7:0] pat,
                       input int vld_pct, input int rand_err_pct, input int abort_beat);
        int          flc;
        int          total;
        int          beats;
        int          errs;
        int          c;
        int          rdy_bad;
        int          i;
        logic [31:0] first;
        logic [31:0] e;
        logic [31:0] d;
        logic [7:0]  patc;
        bit          fbad;
        bit          exp_rdy;
        bit          v;
        bit          f;

        flc   = (fl_in == 0) ? 1 : (fl_in > 128) ? 128 : fl_in;
        patc  = (pat == 8'h00) ? 8'hFF : pat;
        total = flc * nf;

        @(negedge clk);
        start       = 1'b1;
        frame_len   = 8'(fl_in);
        num_frames  = 16'(nf);
        rdy_pattern = pat;
        @(negedge clk);
        start = 1'b0;

        beats = 0; errs = 0; c = 0; rdy_bad = 0; fbad = 0;
        first = 32'hFFFF_FFFF;

        while (done !== 1'b1 && c < 20000) begin
            if (abort_beat >= 0 && beats == abort_beat) begin
                reset  = 1'b1;
                in_vld = 1'b0;
                @(negedge clk);
                check({name, ".abort_busy"}, 32'(busy), 32'd0);
                check({name, ".abort_rdy"}, 32'(in_rdy), 32'd0);
                check({name, ".abort_wc"}, word_cnt, 32'd0);
                check({name, ".abort_done"}, 32'(done), 32'd0);
                reset = 1'b0;
                return;
            end
            // Start pulses during a run must be ignored.
            start = (c == 3);
            frame_len = (c == 3) ? 8'd1 : 8'(fl_in);
            exp_rdy = (nf != 0) && patc[c % 8];
            if (in_rdy !== exp_rdy) rdy_bad++;
            v = (beats < total) && (($urandom % 100) < vld_pct);
            i = beats % flc;
            e = mram[i];
            d = e;
            if (beats == corrupt_beat) d = e + 32'(corrupt_delta);
            else if (($urandom % 100) < rand_err_pct) d = e + $urandom_range(0, 3);
            f = (i == 0) ^ (beats == fst_beat);
            in_vld  = v;
            in_data = v ? d : $urandom;
            in_fst  = f;
            if (v && exp_rdy) begin
                if (beat_bad(d, e)) begin
                    errs++;
                    if (first == 32'hFFFF_FFFF) first = 32'(beats);
                end
                if (f != (i == 0)) fbad = 1'b1;
                beats++;
            end
            @(negedge clk);
            c++;
        end
        in_vld = 1'b0;
        start  = 1'b0;

        check({name, ".done"}, 32'(done), 32'd1);
        check({name, ".beats"}, 32'(beats), 32'(total));
        check({name, ".word_cnt"}, word_cnt, 32'(total));
        check({name, ".err_cnt"}, 32'(err_cnt), 32'(errs));
        check({name, ".first_err"}, first_err_idx, first);
        check({name, ".fst_err"}, 32'(fst_err), 32'(fbad));
        check({name, ".rdy_pattern"}, 32'(rdy_bad), 32'd0);
        check({name, ".idle_rdy"}, 32'(in_rdy), 32'd0);
        check({name, ".busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; frame_len = 8'd0; num_frames = 16'd0;
        rdy_pattern = 8'h00; exp_wr_en = 1'b0; exp_wr_addr = 7'd0; exp_wr_data = 32'd0;
        in_data = 32'd0; in_vld = 1'b0; in_fst = 1'b0;
        corrupt_beat = -1; corrupt_delta = 0; fst_beat = -1;
        repeat (3) @(negedge clk);
        check("reset.rdy", 32'(in_rdy), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.err", 32'(err_cnt), 32'd0);
        check("reset.fst", 32'(fst_err), 32'd0);
        check("reset.first", first_err_idx, 32'hFFFF_FFFF);
        check("reset.wc", word_cnt, 32'd0);
        reset = 1'b0;

        load_ram(1'b0);
        run("t1_clean", 36, 2, 8'hFF, 100, 0, -1);

        corrupt_beat = 40; corrupt_delta = 5;
        run("t2_corrupt40", 36, 2, 8'hFF, 100, 0, -1);
        corrupt_beat = -1;

        run("t3_pat55", 36, 2, 8'h55, 100, 0, -1);

        fst_beat = 3;
        run("t4_fst", 36, 2, 8'hFF, 100, 0, -1);
        fst_beat = -1;
        run("t4_fst_clear", 36, 2, 8'hFF, 100, 0, -1);

        run("t5_abort", 36, 2, 8'hFF, 100, 0, 20);
        run("t5_rerun", 36, 2, 8'hFF, 100, 0, -1);

        corrupt_beat = 10; corrupt_delta = 1;
        run("t6_off1", 36, 1, 8'hFF, 100, 0, -1);
        corrupt_delta = 2;
        run("t6_off2", 36, 1, 8'hFF, 100, 0, -1);
        corrupt_beat = -1;
        run("t6_nf0", 36, 0, 8'hA5, 100, 0, -1);

        load_ram(1'b1);
        run("fl0", 0, 3, 8'h00, 70, 10, -1);
        run("fl200", 200, 1, 8'h93, 80, 5, -1);
        for (int r = 0; r < 6; r++) begin
            fst_beat = ($urandom % 3 == 0) ? int'($urandom_range(0, 30)) : -1;
            run($sformatf("rand%0d", r), int'($urandom_range(0, 140)), int'($urandom_range(1, 3)),
                8'($urandom), int'($urandom_range(30, 100)), 10, -1);
        end
        fst_beat = -1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
